// File: rtl/cndm_micro_tx_desc_proc.sv
// TX descriptor processor: fetches one descriptor at a time, issues the
// packet-data DMA read, waits for its status and emits a completion.
// An empty-queue response parks the block in a polling holdoff.
module cndm_micro_tx_desc_proc #(
    parameter int MAX_LEN  = 2048,
    parameter int POLL_DLY = 64,
    parameter int TAG_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,

    output logic             desc_req,

    input  logic [127:0]     s_axis_desc_tdata,
    input  logic             s_axis_desc_tvalid,
    output logic             s_axis_desc_tready,
    input  logic             s_axis_desc_tlast,
    input  logic             s_axis_desc_tuser,

    output logic [63:0]      m_dma_req_addr,
    output logic [15:0]      m_dma_req_len,
    output logic [TAG_W-1:0] m_dma_req_tag,
    output logic             m_dma_req_valid,
    input  logic             m_dma_req_ready,

    input  logic [TAG_W-1:0] s_dma_sts_tag,
    input  logic [3:0]       s_dma_sts_error,
    input  logic             s_dma_sts_valid,

    output logic [15:0]      m_cpl_len,
    output logic [TAG_W-1:0] m_cpl_tag,
    output logic [3:0]       m_cpl_error,
    output logic             m_cpl_valid,
    input  logic             m_cpl_ready,

    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DESC,
        DROP,
        DMA_REQ,
        DMA_WAIT,
        CPL,
        HOLDOFF
    } state_t;

    // Counter only needs to hold POLL_DLY-1.
    localparam int                HOLD_W      = (POLL_DLY > 1) ? $clog2(POLL_DLY) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD   = HOLD_W'(POLL_DLY - 1);
    localparam logic [16:0]       MAX_LEN_EXT = 17'(MAX_LEN);

    localparam logic [3:0] ERR_ZERO_LEN = 4'h1;
    localparam logic [3:0] ERR_OVER_LEN = 4'h2;

    state_t            state;
    logic [TAG_W-1:0]  tag_cnt;
    logic [TAG_W-1:0]  cur_tag;
    logic [HOLD_W-1:0] hold_cnt;
    logic [15:0]       desc_len;
    logic [63:0]       desc_addr;
    logic              desc_tuser;
    logic [3:0]        cpl_error;

    // Descriptor verdict: next state and completion error for the beat being evaluated
    state_t            eval_state;
    logic [3:0]        eval_err;
    logic [15:0]       eval_len;
    logic              eval_tuser;

    // Bytes 0-3 and tdata[63:48] carry nothing this block uses.
    logic unused_tdata;
    assign unused_tdata = ^{s_axis_desc_tdata[63:48], s_axis_desc_tdata[31:0]};

    // Classify the descriptor: a single-beat descriptor is judged straight off the
    // bus, a multi-beat one from the fields latched on its first beat
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        eval_len   = desc_len;
        eval_tuser = desc_tuser;
        eval_state = DMA_REQ;
        eval_err   = 4'h0;

        if (state == WAIT_DESC) begin
            eval_len   = s_axis_desc_tdata[47:32];
            eval_tuser = s_axis_desc_tuser;
        end

        if (eval_tuser) begin
            eval_state = HOLDOFF;
        end else if (eval_len == 16'd0) begin
            eval_state = CPL;
            eval_err   = ERR_ZERO_LEN;
        end else if ({1'b0, eval_len} > MAX_LEN_EXT) begin
            eval_state = CPL;
            eval_err   = ERR_OVER_LEN;
        end
    end

    // Main sequencer: one descriptor in flight, from request through completion
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state      <= IDLE;
            tag_cnt    <= '0;
            cur_tag    <= '0;
            hold_cnt   <= '0;
            desc_len   <= '0;
            desc_addr  <= '0;
            desc_tuser <= 1'b0;
            cpl_error  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= WAIT_DESC;
                    end
                end

                WAIT_DESC: begin
                    if (s_axis_desc_tvalid && s_axis_desc_tready) begin
                        desc_len   <= s_axis_desc_tdata[47:32];
                        desc_addr  <= s_axis_desc_tdata[127:64];
                        desc_tuser <= s_axis_desc_tuser;
                        if (s_axis_desc_tlast) begin
                            state     <= eval_state;
                            cur_tag   <= tag_cnt;
                            cpl_error <= eval_err;
                            if (eval_state == HOLDOFF) begin
                                hold_cnt <= HOLD_LOAD;
                            end
                        end else begin
                            state <= DROP;
                        end
                    end
                end

                DROP: begin
                    if (s_axis_desc_tvalid && s_axis_desc_tready && s_axis_desc_tlast) begin
                        state     <= eval_state;
                        cur_tag   <= tag_cnt;
                        cpl_error <= eval_err;
                        if (eval_state == HOLDOFF) begin
                            hold_cnt <= HOLD_LOAD;
                        end
                    end
                end

                DMA_REQ: begin
                    if (m_dma_req_ready) begin
                        tag_cnt <= tag_cnt + TAG_W'(1);
                        state   <= DMA_WAIT;
                    end
                end

                DMA_WAIT: begin
                    if (s_dma_sts_valid && (s_dma_sts_tag == cur_tag)) begin
                        cpl_error <= s_dma_sts_error;
                        state     <= CPL;
                    end
                end

                CPL: begin
                    if (m_cpl_ready) begin
                        state <= IDLE;
                    end
                end

                HOLDOFF: begin
                    if (hold_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Output decode: handshake flags follow the state register; payload is held in registers
    assign desc_req           = (state == IDLE) && enable && !rst;
    assign s_axis_desc_tready = (state == WAIT_DESC) || (state == DROP);
    assign m_dma_req_valid    = (state == DMA_REQ);
    assign m_cpl_valid        = (state == CPL);
    assign busy               = (state != IDLE) && (state != HOLDOFF);

    assign m_dma_req_addr = desc_addr;
    assign m_dma_req_len  = desc_len;
    assign m_dma_req_tag  = cur_tag;

    assign m_cpl_len   = desc_len;
    assign m_cpl_tag   = cur_tag;
    assign m_cpl_error = cpl_error;

endmodule
